// File: rtl/uart_pkg.sv
// Shared types and constants for the host-side UART receiver.
// UART_HOST_RX_PARITY_EN adds the PARITY state for 8E1 framing.
package uart_pkg;

    localparam int DATA_W = 8;

`ifdef UART_HOST_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_fifo.sv
// Received-byte FIFO: no fall-through, a push is accepted when full only alongside a pop.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_cnt;
    logic [AW:0]       rd_cnt;
    logic              do_push;
    logic              do_pop;

    // Counts carry one extra bit so the difference distinguishes full from empty.
    assign level   = wr_cnt - rd_cnt;
    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_cnt[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (do_push) wr_cnt <= wr_cnt + 1'b1;
            if (do_pop)  rd_cnt <= rd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_cnt[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_host_rx.sv
// UART receiver (8N1, or 8E1 when UART_HOST_RX_PARITY_EN is defined) feeding a byte FIFO.
// Sampling is centred on each bit using a DIV-cycle bit timer started mid start-bit.
module uart_host_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic                          uart_txd,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int TW  = $clog2(DIV);
    localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);
    localparam logic [TW-1:0] T_HALF = TW'(DIV / 2 - 1);

    logic              sync_p0;
    logic              sync_p1;
    logic              line_d;
    rx_state_t         state;
    logic [TW-1:0]     timer;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_err;
    logic              tick;
    logic              push;
    logic              full;
    logic              empty;

    assign tick     = (timer == '0);
    assign push     = (state == STOP) && tick && sync_p1 && !par_err;
    assign rx_valid = !empty;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync_p0   <= 1'b1;
            sync_p1   <= 1'b1;
            line_d    <= 1'b1;
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Stage boundary: two-flop synchronizer, then edge-detect history.
            sync_p0   <= uart_txd;
            sync_p1   <= sync_p0;
            line_d    <= sync_p1;
            frame_err <= 1'b0;
            overrun   <= push && full && !(rx_ready && !empty);

            if (state != IDLE && state != BREAK && !tick) timer <= timer - 1'b1;

            case (state)
                IDLE: begin
                    if (line_d && !sync_p1) begin
                        state   <= START;
                        timer   <= T_HALF;
                        bit_cnt <= '0;
                        par_err <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!sync_p1) begin
                            state <= DATA;
                            timer <= T_FULL;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= {sync_p1, shreg[DATA_W-1:1]};
                        timer <= T_FULL;
                        if (bit_cnt == 3'(DATA_W - 1)) begin
`ifdef UART_HOST_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_HOST_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        par_err <= sync_p1 ^ (^shreg);
                        timer   <= T_FULL;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        // A parity error reports at the stop sample; a low stop bit means a break may follow.
                        if (!sync_p1) begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end else begin
                            frame_err <= par_err;
                            state     <= IDLE;
                        end
                    end
                end
                BREAK: begin
                    if (sync_p1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .push  (push),
        .din   (shreg),
        .pop   (rx_ready),
        .dout  (rx_data),
        .empty (empty),
        .full  (full),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_uart_host_rx.sv
// Directed bench for uart_host_rx at DIV=10; define UART_HOST_RX_PARITY_EN to exercise 8E1 framing.
module tb_uart_host_rx;
    import uart_pkg::*;

`ifdef UART_HOST_RX_PARITY_EN
    localparam int LAT = 108;
`else
    localparam int LAT = 98;
`endif

    logic       clk = 1'b0;
    logic       reset_reset = 1'b1;
    logic       uart_txd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic [3:0] fifo_level;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int valid_cycles = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int last_rise = 0;
    logic prev_valid = 1'b0;
    logic [7:0] popped [$];

    uart_host_rx #(
        .CLK_HZ     (1000000),
        .BAUD       (100000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (reset_reset),
        .uart_txd    (uart_txd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cumulative event counters sampled mid-cycle; tests work from deltas.
    always @(negedge clk) begin
        if (rx_valid) valid_cycles++;
        if (rx_valid && !prev_valid) last_rise = cyc;
        prev_valid = rx_valid;
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (rx_valid && rx_ready) popped.push_back(rx_data);
    end

    task automatic drive(input logic v, input int n);
        uart_txd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len, input logic bad_par);
        @(negedge clk);
        start_cyc = cyc;
        drive(1'b0, 10);
        for (int i = 0; i < 8; i++) drive(b[i], 10);
`ifdef UART_HOST_RX_PARITY_EN
        drive((^b) ^ bad_par, 10);
`else
        if (bad_par) $display("[TB] note: parity request ignored in 8N1 build");
`endif
        drive(stop_v, stop_len);
        uart_txd = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        tests++; if (fifo_level !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected IDLE", dut.state); end
        reset_reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int n0, v0, f0;
        rx_ready = 1'b1;
        n0 = popped.size(); v0 = valid_cycles; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, 10, 1'b0);
        repeat (10) @(negedge clk);
        tests++;
        if (popped.size() != n0 + 1) begin
            fails++; $display("FAIL single_count: got %0d bytes expected 1", popped.size() - n0);
        end else begin
            tests++; if (popped[n0] !== 8'hA5) begin fails++; $display("FAIL single_data: got %h expected a5", popped[n0]); end
        end
        tests++; if (valid_cycles - v0 != 1) begin fails++; $display("FAIL single_valid_len: got %0d cycles expected 1", valid_cycles - v0); end
        tests++; if (ferr_cnt != f0) begin fails++; $display("FAIL single_frame_err: got %0d pulses expected 0", ferr_cnt - f0); end
        tests++; if (last_rise - start_cyc != LAT) begin fails++; $display("FAIL single_latency: got %0d cycles expected %0d", last_rise - start_cyc, LAT); end
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = valid_cycles; f0 = ferr_cnt;
        @(negedge clk);
        drive(1'b0, 3);
        uart_txd = 1'b1;
        repeat (30) @(negedge clk);
        tests++; if (valid_cycles != v0) begin fails++; $display("FAIL glitch_valid: got %0d cycles expected 0", valid_cycles - v0); end
        tests++; if (ferr_cnt != f0) begin fails++; $display("FAIL glitch_frame_err: got %0d pulses expected 0", ferr_cnt - f0); end
        tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL glitch_state: got %0d expected IDLE", dut.state); end
    endtask

    task automatic test_frame_error();
        int n0, f0;
        rx_ready = 1'b1;
        n0 = popped.size(); f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 20, 1'b0);
        repeat (10) @(negedge clk);
        tests++; if (ferr_cnt - f0 != 1) begin fails++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_cnt - f0); end
        tests++; if (popped.size() != n0) begin fails++; $display("FAIL ferr_no_push: got %0d bytes expected 0", popped.size() - n0); end
        tests++; if (fifo_level !== 4'd0) begin fails++; $display("FAIL ferr_level: got %0d expected 0", fifo_level); end
        send_frame(8'h3C, 1'b1, 10, 1'b0);
        repeat (10) @(negedge clk);
        tests++;
        if (popped.size() != n0 + 1) begin
            fails++; $display("FAIL ferr_recover_count: got %0d bytes expected 1", popped.size() - n0);
        end else begin
            tests++; if (popped[n0] !== 8'h3C) begin fails++; $display("FAIL ferr_recover_data: got %h expected 3c", popped[n0]); end
        end
    endtask

    task automatic test_overrun();
        int n0, o0;
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        for (int b = 0; b < 9; b++) send_frame(8'(b), 1'b1, 10, 1'b0);
        repeat (5) @(negedge clk);
        tests++; if (fifo_level !== 4'd8) begin fails++; $display("FAIL ovr_level: got %0d expected 8", fifo_level); end
        tests++; if (ovr_cnt - o0 != 1) begin fails++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_cnt - o0); end
        tests++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid: got %b expected 1", rx_valid); end
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL ovr_head: got %h expected 00", rx_data); end
        n0 = popped.size();
        rx_ready = 1'b1;
        repeat (12) @(negedge clk);
        tests++;
        if (popped.size() != n0 + 8) begin
            fails++; $display("FAIL ovr_pop_count: got %0d expected 8", popped.size() - n0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (popped[n0 + i] !== 8'(i)) begin fails++; $display("FAIL ovr_pop_order: index %0d got %h expected %h", i, popped[n0 + i], 8'(i)); end
            end
        end
        tests++; if (fifo_level !== 4'd0) begin fails++; $display("FAIL ovr_drained: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_reset_mid_frame();
        int n0, f0;
        logic [7:0] b;
        b = 8'h55;
        rx_ready = 1'b1;
        n0 = popped.size(); f0 = ferr_cnt;
        @(negedge clk);
        drive(1'b0, 10);
        for (int i = 0; i < 4; i++) drive(b[i], 10);
        uart_txd = b[4];
        repeat (5) @(negedge clk);
        reset_reset = 1'b1;
        repeat (2) @(negedge clk);
        reset_reset = 1'b0;
        uart_txd = 1'b1;
        repeat (30) @(negedge clk);
        tests++; if (popped.size() != n0) begin fails++; $display("FAIL rst_mid_push: got %0d bytes expected 0", popped.size() - n0); end
        tests++; if (ferr_cnt != f0) begin fails++; $display("FAIL rst_mid_frame_err: got %0d pulses expected 0", ferr_cnt - f0); end
        tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL rst_mid_state: got %0d expected IDLE", dut.state); end
        send_frame(8'h66, 1'b1, 10, 1'b0);
        repeat (10) @(negedge clk);
        tests++;
        if (popped.size() != n0 + 1) begin
            fails++; $display("FAIL rst_mid_next_count: got %0d bytes expected 1", popped.size() - n0);
        end else begin
            tests++; if (popped[n0] !== 8'h66) begin fails++; $display("FAIL rst_mid_next_data: got %h expected 66", popped[n0]); end
        end
    endtask

`ifdef UART_HOST_RX_PARITY_EN
    task automatic test_parity();
        int n0, f0;
        rx_ready = 1'b1;
        n0 = popped.size(); f0 = ferr_cnt;
        send_frame(8'h07, 1'b1, 10, 1'b1);
        repeat (10) @(negedge clk);
        tests++; if (ferr_cnt - f0 != 1) begin fails++; $display("FAIL parity_bad_err: got %0d pulses expected 1", ferr_cnt - f0); end
        tests++; if (popped.size() != n0) begin fails++; $display("FAIL parity_bad_push: got %0d bytes expected 0", popped.size() - n0); end
        send_frame(8'h07, 1'b1, 10, 1'b0);
        repeat (10) @(negedge clk);
        tests++;
        if (popped.size() != n0 + 1) begin
            fails++; $display("FAIL parity_good_count: got %0d bytes expected 1", popped.size() - n0);
        end else begin
            tests++; if (popped[n0] !== 8'h07) begin fails++; $display("FAIL parity_good_data: got %h expected 07", popped[n0]); end
        end
        tests++; if (ferr_cnt - f0 != 1) begin fails++; $display("FAIL parity_good_err: got %0d pulses expected 1", ferr_cnt - f0); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
`ifdef UART_HOST_RX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_host_rx.md
UART_HOST_RX -- requirements
Module: uart_host_rx

Interface
REQ-001 Parameter: CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter: BAUD, default 115200, line bit rate.
REQ-003 Parameter: FIFO_DEPTH, default 8, received-byte buffer depth, power of two, 2..64.
REQ-004 Port: clk_clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 Port: reset_reset, input, 1, reset; synchronous, active-high.
REQ-006 Port: uart_txd, input, 1, serial line driven by the system's UART transmitter; asynchronous; idle high.
REQ-007 Port: rx_data, output, 8, byte at the FIFO head.
REQ-008 Port: rx_valid, output, 1, FIFO non-empty.
REQ-009 Port: rx_ready, input, 1, consumer accepts the head byte.
REQ-010 Port: frame_err, output, 1, one-cycle pulse when a stop bit is sampled low.
REQ-011 Port: overrun, output, 1, one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-012 Port: fifo_level, output, $clog2(FIFO_DEPTH)+1, bytes currently buffered.

Function
REQ-013 DIV = round(CLK_HZ/BAUD), computed at elaboration; the bit-timer counter shall be $clog2(DIV) bits wide and count DIV-1 down to 0.
REQ-014 uart_txd shall pass through a 2-flop synchronizer before any use.
REQ-015 FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP, BREAK.
REQ-016 IDLE: a synchronized 1->0 transition shall enter START and load the timer with DIV/2-1.
REQ-017 START: on timer expiry, a line value of 0 enters DATA with the timer at DIV-1; a value of 1 is a glitch and returns to IDLE with no output.
REQ-018 DATA: 8 bits shall be sampled LSB first, one per DIV cycles, into a shift register; after bit 7 the FSM enters PARITY or STOP.
REQ-019 STOP: a sample of 1 pushes the byte to the FIFO and returns to IDLE; a sample of 0 pulses frame_err, discards the byte, and enters BREAK.
REQ-020 BREAK: the FSM waits for the synchronized line to be 1, then enters IDLE; no start is detected in BREAK.
REQ-021 Latency: rx_valid shall assert on the cycle after the stop-bit sample cycle when the FIFO was empty; there is no fall-through.
REQ-022 Handshake: a pop occurs when rx_valid and rx_ready are both 1; rx_data shall hold stable while rx_valid=1 and no pop occurs.
REQ-023 Push when full with no pop: the byte is dropped, overrun pulses, and FIFO contents are unchanged.
REQ-024 Push when full with a same-cycle pop: both succeed, overrun stays 0, and fifo_level is unchanged.
REQ-025 Read and write pointers shall wrap modulo FIFO_DEPTH; fifo_level = write count minus read count.

Reset
REQ-026 Reset shall put the FSM in IDLE, set both synchronizer flops to 1, zero the timer, shift register, pointers and fifo_level, and drive rx_valid, frame_err and overrun to 0.
REQ-027 Reset asserted mid-frame shall abort the frame with no push and no error pulse; after release, a start is detected only on a fresh falling edge.

Configuration
REQ-028 Macro UART_HOST_RX_PARITY_EN, when defined, shall add the PARITY state and sample one even-parity bit after bit 7.
REQ-029 On a parity mismatch the byte shall be discarded and frame_err shall pulse at the stop-bit sample cycle.
REQ-030 Without the macro, frames are 8N1, the PARITY state does not exist, and ports are identical.

Structure
REQ-031 Package uart_pkg shall hold the FSM state enum and the data-width constant (8).
REQ-032 The FIFO shall be the sub-module uart_rx_fifo, with parameter DEPTH and ports push/din/pop/dout/empty/full/level.

Verification (CLK_HZ=1000000, BAUD=100000, DIV=10)
REQ-033 Send 0xA5 as 8N1, rx_ready=1 -> rx_data=0xA5, rx_valid high exactly 1 cycle, frame_err=0.
REQ-034 Drive a low glitch of 3 cycles on an idle line -> no rx_valid, no frame_err, FSM back in IDLE.
REQ-035 Send 0x3C with the stop bit forced 0 for 20 cycles -> frame_err pulses once, FIFO stays empty, and the next 0x3C after the line goes high is received.
REQ-036 Hold rx_ready=0 and send 9 bytes 0x00..0x08 -> fifo_level=8, overrun pulses once, and the pop order is 0x00..0x07.
REQ-037 Assert reset_reset during bit 4 of 0x55 -> no push; the following 0x66 is received correctly.
REQ-038 With UART_HOST_RX_PARITY_EN, send 0x07 with parity bit 0 -> frame_err pulses and no byte is pushed; with parity bit 1 -> 0x07 is received.
